bcd_7seg_scan: RTL

//  Multiplexed 3-digit 7-segment display driver for the refrigeration panel.

---
 rtl/disp_pkg.sv | 28 ++
 rtl/bcd_7seg_scan_if.sv | 22 ++
 rtl/seg_decoder.sv | 28 ++
 rtl/bcd_7seg_scan.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// disp_pkg: shared constants for the 3-digit multiplexed 7-segment driver.
//   SEG_0..SEG_9, SEG_DASH, SEG_OFF : logical segment patterns {g,f,e,d,c,b,a}, 1 = lit
//   N_DIGITS                        : digits on the shared segment bus
//   scan_e                          : scan FSM state, value equals the digit index
package disp_pkg;

   localparam int N_DIGITS = 3;

   localparam logic [6:0] SEG_0    = 7'h3F;
   localparam logic [6:0] SEG_1    = 7'h06;
   localparam logic [6:0] SEG_2    = 7'h5B;
   localparam logic [6:0] SEG_3    = 7'h4F;
   localparam logic [6:0] SEG_4    = 7'h66;
   localparam logic [6:0] SEG_5    = 7'h6D;
   localparam logic [6:0] SEG_6    = 7'h7D;
   localparam logic [6:0] SEG_7    = 7'h07;
   localparam logic [6:0] SEG_8    = 7'h7F;
   localparam logic [6:0] SEG_9    = 7'h6F;
   localparam logic [6:0] SEG_DASH = 7'h40;
   localparam logic [6:0] SEG_OFF  = 7'h00;

   typedef enum logic [1:0] {
      SCAN_U = 2'd0,
      SCAN_T = 2'd1,
      SCAN_H = 2'd2
   } scan_e;

endpackage

// File: rtl/bcd_7seg_scan_if.sv
// bcd_7seg_scan_if: value/display bundle of the scan driver.
//   bcd[11:0]   packed BCD {hundreds, tens, units}
//   bcd_valid   1-cycle strobe, bcd sampled on that cycle
//   blink       alarm blink level
//   seg[6:0]    segment bus {g,f,e,d,c,b,a} (physical polarity)
//   an[2:0]     digit enables, an[0]=units (physical polarity)
//   frame_done  1-cycle pulse on digit wrap hundreds->units
// master = value producer / panel observer, slave = the driver.
interface bcd_7seg_scan_if;
   import disp_pkg::*;

   logic [11:0]         bcd;
   logic                bcd_valid;
   logic                blink;
   logic [6:0]          seg;
   logic [N_DIGITS-1:0] an;
   logic                frame_done;

   modport master (output bcd, bcd_valid, blink, input seg, an, frame_done);
   modport slave  (input bcd, bcd_valid, blink, output seg, an, frame_done);

endinterface

// File: rtl/seg_decoder.sv
// seg_decoder: combinational BCD nibble to logical 7-segment pattern.
//   nib[3:0] in  : digit value
//   seg[6:0] out : {g,f,e,d,c,b,a}, 1 = lit; A..F show a dash
module seg_decoder
   import disp_pkg::*;
(
   input  logic [3:0] nib,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_DASH;
      case (nib)
         4'd0: seg = SEG_0;
         4'd1: seg = SEG_1;
         4'd2: seg = SEG_2;
         4'd3: seg = SEG_3;
         4'd4: seg = SEG_4;
         4'd5: seg = SEG_5;
         4'd6: seg = SEG_6;
         4'd7: seg = SEG_7;
         4'd8: seg = SEG_8;
         4'd9: seg = SEG_9;
         default: seg = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/bcd_7seg_scan.sv
// bcd_7seg_scan: multiplexed 3-digit 7-segment driver with tear-free
// double buffering and alarm blink.
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   bus.slave  bcd/bcd_valid/blink in, seg/an/frame_done out (registered)
// Parameters: DIV clocks per digit slot (>=2), BLINK_FRAMES frames per blink
// half-period (>=1), ACTIVE_LOW inverts seg/an at the output flops.
// Build option: define LZ_BLANK_EN to blank leading-zero hundreds/tens digits.
module bcd_7seg_scan
   import disp_pkg::*;
#(
   parameter int DIV          = 50000,
   parameter int BLINK_FRAMES = 166,
   parameter bit ACTIVE_LOW   = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   bcd_7seg_scan_if.slave    bus
);

   localparam int CW = $clog2(DIV);
   localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
   localparam logic [BW-1:0] BLK_MAX = BW'(BLINK_FRAMES - 1);
   localparam logic [6:0]          SEG_IDLE = ACTIVE_LOW ? 7'h7F : 7'h00;
   localparam logic [N_DIGITS-1:0] AN_IDLE  = ACTIVE_LOW ? '1 : '0;

   logic [CW-1:0]       cnt;
   logic                tick;
   scan_e               idx, idx_nxt;
   logic                wrap;
   logic                pend;
   logic [11:0]         pend_reg, disp_reg;
   logic [BW-1:0]       blink_cnt;
   logic                blink_ph;
   logic [3:0]          nib;
   logic [6:0]          dec_seg, seg_l, seg_q;
   logic [N_DIGITS-1:0] an_l, an_q;
   logic                fd_q;

   // slot prescaler
   assign tick = (cnt == CNT_MAX);
   assign wrap = tick && (idx == SCAN_H);

   always_ff @(posedge clk) begin
      if (rst || tick) cnt <= '0;
      else             cnt <= cnt + 1'b1;
   end

   // scan FSM
   always_ff @(posedge clk) begin
      if (rst) idx <= SCAN_U;
      else     idx <= idx_nxt;
   end

   always_comb begin
      idx_nxt = idx;
      if (tick) begin
         case (idx)
            SCAN_U:  idx_nxt = SCAN_T;
            SCAN_T:  idx_nxt = SCAN_H;
            default: idx_nxt = SCAN_U;
         endcase
      end
   end

   // Double buffer: strobes land in pend_reg and only reach disp_reg on the
   // frame wrap. A strobe on the wrap cycle itself goes straight through, and
   // the commit clearing pend takes priority over that strobe setting it.
   always_ff @(posedge clk) begin
      if (rst) begin
         pend     <= 1'b0;
         pend_reg <= '0;
         disp_reg <= '0;
      end else begin
         if (bus.bcd_valid) begin
            pend_reg <= bus.bcd;
            pend     <= 1'b1;
         end
         if (wrap) begin
            if (bus.bcd_valid) begin
               disp_reg <= bus.bcd;
               pend     <= 1'b0;
            end else if (pend) begin
               disp_reg <= pend_reg;
               pend     <= 1'b0;
            end
         end
      end
   end

   // blink phase, held in the lit phase while blink is low
   always_ff @(posedge clk) begin
      if (rst || !bus.blink) begin
         blink_cnt <= '0;
         blink_ph  <= 1'b0;
      end else if (wrap) begin
         if (blink_cnt == BLK_MAX) begin
            blink_cnt <= '0;
            blink_ph  <= ~blink_ph;
         end else begin
            blink_cnt <= blink_cnt + 1'b1;
         end
      end
   end

   // single shared decoder, nibble selected by the current slot
   always_comb begin
      case (idx)
         SCAN_T:  nib = disp_reg[7:4];
         SCAN_H:  nib = disp_reg[11:8];
         default: nib = disp_reg[3:0];
      endcase
   end

   seg_decoder u_dec (
      .nib (nib),
      .seg (dec_seg)
   );

   always_comb begin
      seg_l = dec_seg;
      case (idx)
         SCAN_U:  an_l = 3'b001;
         SCAN_T:  an_l = 3'b010;
         SCAN_H:  an_l = 3'b100;
         default: an_l = 3'b000;
      endcase
`ifdef LZ_BLANK_EN
      // digit stays enabled so the scan duty is unchanged, only segments go dark
      if (idx == SCAN_H && disp_reg[11:8] == 4'd0) seg_l = SEG_OFF;
      if (idx == SCAN_T && disp_reg[11:4] == 8'd0) seg_l = SEG_OFF;
`endif
      if (bus.blink && blink_ph) begin
         seg_l = SEG_OFF;
         an_l  = '0;
      end
   end

   // output flops; polarity applied here so logic above stays logical
   always_ff @(posedge clk) begin
      if (rst) begin
         seg_q <= SEG_IDLE;
         an_q  <= AN_IDLE;
         fd_q  <= 1'b0;
      end else begin
         seg_q <= ACTIVE_LOW ? ~seg_l : seg_l;
         an_q  <= ACTIVE_LOW ? ~an_l  : an_l;
         fd_q  <= wrap;
      end
   end

   assign bus.seg        = seg_q;
   assign bus.an         = an_q;
   assign bus.frame_done = fd_q;

endmodule
